// File: rtl/regdump_pkg.sv
// Shared types and constants for the register-file UART dump engine.
// REGDUMP_INDEX_EN: when defined, each register's data bytes are preceded by an index byte.
package regdump_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSend,
    StDone
  } state_e;

  localparam int unsigned UART_FRAME_BITS = 10;

`ifdef REGDUMP_INDEX_EN
  localparam int unsigned BYTES_PER_REG = 5;
`else
  localparam int unsigned BYTES_PER_REG = 4;
`endif

  // Data bytes leave MSB byte first.
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = word[31:24];
      3'd1:    b = word[23:16];
      3'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte transmitter: owns the baud counter and the 10-bit frame shifter.
// ready_o is also high during the final stop-bit cycle so a new byte can follow with no gap.
module uart_tx_byte
  import regdump_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       ready_o
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BaudLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] BitLast = 4'(UART_FRAME_BITS - 1);

  logic            active_q, active_d;
  logic [CntW-1:0] baud_q, baud_d;
  logic [3:0]      bit_q, bit_d;
  logic [9:0]      shift_q, shift_d;
  logic            bit_end;

  assign bit_end = active_q && (baud_q == BaudLast);
  assign ready_o = !active_q || (bit_end && (bit_q == BitLast));
  assign tx_o    = active_q ? shift_q[0] : 1'b1;

  always_comb begin
    active_d = active_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    if (load_i && ready_o) begin
      active_d = 1'b1;
      baud_d   = '0;
      bit_d    = '0;
      shift_d  = {1'b1, data_i, 1'b0};
    end else if (bit_end) begin
      baud_d = '0;
      if (bit_q == BitLast) begin
        active_d = 1'b0;
      end else begin
        bit_d   = bit_q + 4'd1;
        shift_d = {1'b1, shift_q[9:1]};
      end
    end else if (active_q) begin
      baud_d = baud_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '1;
    end else begin
      active_q <= active_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
    end
  end

endmodule

// File: rtl/regfile_uart_dump.sv
// Reads registers FIRST_REG..LAST_REG through a spare read port and streams them out as UART bytes.
// REGDUMP_INDEX_EN adds a leading {3'b000, index} byte per register.
module regfile_uart_dump
  import regdump_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned FIRST_REG    = 0,
  parameter int unsigned LAST_REG     = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  output logic [4:0]  rd_addr_o,
  input  logic [31:0] rd_data_i,
  output logic        tx_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [4:0] FirstAddr = 5'(FIRST_REG);
  localparam logic [4:0] LastAddr  = 5'(LAST_REG);
  localparam logic [2:0] LastByte  = 3'(BYTES_PER_REG - 1);

  state_e      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [4:0]  rd_addr_q, rd_addr_d;

  logic        tx_ready;
  logic        tx_load;
  logic [2:0]  tx_idx;
  logic [31:0] tx_src;
  logic [7:0]  tx_data;
  logic        last_byte;

  assign last_byte = (byte_cnt_q == LastByte);
  assign rd_addr_o = rd_addr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      word_q     <= '0;
      byte_cnt_q <= '0;
      rd_addr_q  <= FirstAddr;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    rd_addr_d  = rd_addr_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          rd_addr_d = FirstAddr;
          state_d   = StLoad;
        end
      end
      StLoad: begin
        word_d     = rd_data_i;
        byte_cnt_d = '0;
        state_d    = StSend;
      end
      StSend: begin
        if (tx_ready) begin
          if (!last_byte) begin
            byte_cnt_d = byte_cnt_q + 3'd1;
          end else if (rd_addr_q == LastAddr) begin
            state_d = StDone;
          end else begin
            rd_addr_d = rd_addr_q + 5'd1;
            state_d   = StLoad;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // The first byte launches straight from the read port while the word is being captured.
  always_comb begin
    tx_load = 1'b0;
    tx_idx  = 3'd0;
    tx_src  = word_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      StIdle: ;
      StLoad: begin
        busy_o  = 1'b1;
        tx_load = 1'b1;
        tx_src  = rd_data_i;
      end
      StSend: begin
        busy_o  = 1'b1;
        tx_load = tx_ready && !last_byte;
        tx_idx  = byte_cnt_q + 3'd1;
      end
      StDone:  done_o = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
`ifdef REGDUMP_INDEX_EN
    tx_data = (tx_idx == 3'd0) ? {3'b000, rd_addr_q} : word_byte(tx_src, tx_idx - 3'd1);
`else
    tx_data = word_byte(tx_src, tx_idx);
`endif
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx_byte (
    .clk    (clk),
    .reset  (reset),
    .load_i (tx_load),
    .data_i (tx_data),
    .tx_o   (tx_o),
    .ready_o(tx_ready)
  );

endmodule

// File: tb/tb_regfile_uart_dump.sv
// Randomized self-checking bench: decodes the UART stream and compares it with a byte list
// built from a snapshot of the modelled register file.
module tb_regfile_uart_dump;

  localparam int unsigned C = 4;
`ifdef REGDUMP_INDEX_EN
  localparam int B = 5;
`else
  localparam int B = 4;
`endif
  localparam int P     = 1 + B * 10 * int'(C);
  localparam int LIMIT = 32 * P + 50;

  logic        clk = 1'b0;
  logic        reset;
  logic        start0, start1;
  logic [4:0]  addr0, addr1;
  logic [31:0] data0, data1;
  logic        tx0, tx1, busy0, busy1, done0, done1;

  logic [31:0] rf [32];
  logic [7:0]  rx0 [$];
  logic [7:0]  rx1 [$];
  logic [7:0]  expq [$];

  int checks = 0;
  int errors = 0;

  int         mcnt0 = -1;
  int         mcnt1 = -1;
  logic [7:0] msh0 = 8'h00;
  logic [7:0] msh1 = 8'h00;
  bit         mferr0 = 1'b0;
  bit         mferr1 = 1'b0;
  bit         got0, got1;

  always #5 clk = ~clk;

  assign data0 = (addr0 == 5'd0) ? 32'd0 : rf[addr0];
  assign data1 = (addr1 == 5'd0) ? 32'd0 : rf[addr1];

  regfile_uart_dump #(
    .CLKS_PER_BIT(C),
    .FIRST_REG   (0),
    .LAST_REG    (31)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start_i  (start0),
    .rd_addr_o(addr0),
    .rd_data_i(data0),
    .tx_o     (tx0),
    .busy_o   (busy0),
    .done_o   (done0)
  );

  regfile_uart_dump #(
    .CLKS_PER_BIT(C),
    .FIRST_REG   (29),
    .LAST_REG    (29)
  ) dut29 (
    .clk      (clk),
    .reset    (reset),
    .start_i  (start1),
    .rd_addr_o(addr1),
    .rd_data_i(data1),
    .tx_o     (tx1),
    .busy_o   (busy1),
    .done_o   (done1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One negedge step of an 8N1 receiver sampling each bit in its middle.
  task automatic mon_step(input logic txv, inout int cnt, inout logic [7:0] sh, inout bit ferr,
                          output bit got);
    got = 1'b0;
    if (cnt < 0) begin
      if (txv == 1'b0) cnt = 0;
    end else begin
      cnt++;
      if (cnt == 2) begin
        if (txv !== 1'b0) ferr = 1'b1;
      end else if (cnt >= 6 && cnt <= 34 && (cnt - 2) % 4 == 0) begin
        sh = {txv, sh[7:1]};
      end else if (cnt == 38) begin
        if (txv !== 1'b1) ferr = 1'b1;
        got = 1'b1;
        cnt = -1;
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (reset) begin
      mcnt0  = -1;
      mferr0 = 1'b0;
    end else begin
      mon_step(tx0, mcnt0, msh0, mferr0, got0);
      if (got0) begin
        rx0.push_back(msh0);
        check_eq("frame0", 32'(mferr0), 32'd0);
        mferr0 = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (reset) begin
      mcnt1  = -1;
      mferr1 = 1'b0;
    end else begin
      mon_step(tx1, mcnt1, msh1, mferr1, got1);
      if (got1) begin
        rx1.push_back(msh1);
        check_eq("frame29", 32'(mferr1), 32'd0);
        mferr1 = 1'b0;
      end
    end
  end

  task automatic build_exp(input int first, input int last);
    expq.delete();
    for (int r = first; r <= last; r++) begin
      logic [31:0] w;
      w = (r == 0) ? 32'd0 : rf[r];
`ifdef REGDUMP_INDEX_EN
      expq.push_back(8'(r));
`endif
      for (int j = 0; j < 4; j++) expq.push_back(8'(w >> (24 - 8 * j)));
    end
  endtask

  task automatic cmp_bytes(input string tag, input logic [7:0] got [$]);
    check_eq({tag, "_count"}, 32'(got.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size() && i < got.size(); i++)
      check_eq($sformatf("%s[%0d]", tag, i), 32'(got[i]), 32'(expq[i]));
  endtask

  // Full 0..31 dump on dut; returns the edge index at which done was first seen.
  task automatic dump0(input bit hold, input bit jitter, input bit do_write, output int t_done);
    int ndone;
    ndone = 0;
    build_exp(0, 31);
    rx0.delete();
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    check_eq("busy_accept", 32'(busy0), 32'd1);
    if (!hold) start0 = 1'b0;
    t_done = -1;
    for (int k = 1; k <= LIMIT; k++) begin
      @(posedge clk);
      #1;
      if (do_write && k == 5 * P + 1) rf[5] = 32'hDEADBEEF;
      if (done0) begin
        ndone++;
        if (t_done < 0) t_done = k;
      end
      if (!hold) start0 = (jitter && !done0 && t_done < 0) ? ($urandom_range(0, 7) == 0) : 1'b0;
      if (t_done >= 0 && k == t_done + 1) break;
    end
    check_eq("done_cycle", 32'(t_done), 32'(32 * P));
    check_eq("done_count", 32'(ndone), 32'd1);
    check_eq("done_width", 32'(done0), 32'd0);
    check_eq("busy_after_done", 32'(busy0), 32'd0);
    cmp_bytes("byte", rx0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int  t;
    int  nd;
    bit  found;
    reset  = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h01020300 + 32'(i);
    repeat (3) @(negedge clk);
    check_eq("rst_tx", 32'(tx0), 32'd1);
    check_eq("rst_busy", 32'(busy0), 32'd0);
    check_eq("rst_done", 32'(done0), 32'd0);
    check_eq("rst_addr", 32'(addr0), 32'd0);
    check_eq("rst_addr29", 32'(addr1), 32'd29);
    reset = 1'b0;

    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("idle_rst_tx", 32'(tx0), 32'd1);
    check_eq("idle_rst_busy", 32'(busy0), 32'd0);
    check_eq("idle_rst_addr", 32'(addr0), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single-register range.
    build_exp(29, 29);
    rx1.delete();
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    check_eq("busy29_accept", 32'(busy1), 32'd1);
    t  = -1;
    nd = 0;
    for (int k = 1; k <= 2 * P; k++) begin
      @(posedge clk);
      #1;
      if (done1) begin
        nd++;
        if (t < 0) t = k;
      end
    end
    check_eq("done29_cycle", 32'(t), 32'(P));
    check_eq("done29_count", 32'(nd), 32'd1);
    cmp_bytes("byte29", rx1);

    // Start held high throughout: one dump, then re-accepted only from IDLE.
    dump0(1'b1, 1'b0, 1'b0, t);
    @(posedge clk);
    #1;
    check_eq("reaccept_busy", 32'(busy0), 32'd1);
    start0 = 1'b0;
    found  = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (tx0 == 1'b0 && k > 20) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("saw_tx_low", 32'(found), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("byte_rst_tx", 32'(tx0), 32'd1);
    check_eq("byte_rst_busy", 32'(busy0), 32'd0);
    check_eq("byte_rst_done", 32'(done0), 32'd0);
    check_eq("byte_rst_addr", 32'(addr0), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Random contents, random start pulses mid-dump, write to r5 right after capture.
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    dump0(1'b0, 1'b1, 1'b1, t);
    repeat (3) @(negedge clk);
    check_eq("idle_no_requeue", 32'(busy0), 32'd0);

    // New dump picks up the written value.
    dump0(1'b0, 1'b0, 1'b0, t);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
